// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - iNES image loader writing PRG/CHR ROM from a byte stream
//
// Purpose: parses a 16-byte iNES header, optionally skips a 512-byte trainer,
// then writes the PRG and CHR payloads into external ROMs with registered
// single-cycle write strobes.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   start_in                  pulse: begin loading a new image
//   data_in, data_valid_in    image byte stream
//   data_ready_out            byte accepted this cycle when valid
//   cfg_out, cfg_upd_out      {hdr4,hdr5,hdr6,hdr7,hdr8} and its update pulse
//   prg_nce_out, prg_a_out, prg_r_nw_out, prg_d_out   PRG ROM write port
//   chr_a_out, chr_r_nw_out, chr_d_out                CHR ROM write port
//   done_out, err_out         image loaded / image rejected
module rom_loader (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  output logic        data_ready_out,
  output logic [39:0] cfg_out,
  output logic        cfg_upd_out,
  output logic        prg_nce_out,
  output logic [14:0] prg_a_out,
  output logic        prg_r_nw_out,
  output logic [7:0]  prg_d_out,
  output logic [13:0] chr_a_out,
  output logic        chr_r_nw_out,
  output logic [7:0]  chr_d_out,
  output logic        done_out,
  output logic        err_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TRAIN, S_PRG, S_CHR, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [7:0]  hdr4_q, hdr5_q, hdr6_q, hdr7_q, hdr8_q;
  logic [39:0] cfg_q;
  logic        cfg_upd_q;
  logic        prg_we_q, chr_we_q;
  logic [14:0] prg_a_q;
  logic [7:0]  prg_d_q, chr_d_q;
  logic [12:0] chr_a_q;

  logic        xfer, cfg_ld, prg_wr, chr_wr, hdr_bad;
  logic [7:0]  magic;
  logic [14:0] prg_last;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cfg_ld         = 1'b0;
    prg_wr         = 1'b0;
    chr_wr         = 1'b0;
    case (cnt_q[1:0])
      2'd0:    magic = 8'h4E;
      2'd1:    magic = 8'h45;
      2'd2:    magic = 8'h53;
      default: magic = 8'h1A;
    endcase
    prg_last       = (hdr4_q == 8'd1) ? 15'd16383 : 15'd32767;
    hdr_bad        = !((hdr4_q == 8'd1) || (hdr4_q == 8'd2)) || (hdr5_q > 8'd1);
    data_ready_out = (state_q == S_HDR) || (state_q == S_TRAIN) ||
                     (state_q == S_PRG) || (state_q == S_CHR);
    xfer           = data_valid_in && data_ready_out;
    done_out       = (state_q == S_DONE);
    err_out        = (state_q == S_ERR);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_in) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          cnt_d = cnt_q + 15'd1;
          if ((cnt_q < 15'd4) && (data_in != magic)) begin
            state_d = S_ERR;
            cnt_d   = '0;
          end else if (cnt_q == 15'd15) begin
            cnt_d = '0;
            if (hdr_bad) begin
              state_d = S_ERR;
            end else begin
              cfg_ld  = 1'b1;
              state_d = hdr6_q[2] ? S_TRAIN : S_PRG;
            end
          end
        end
      end
      S_TRAIN: begin
        if (xfer) begin
          cnt_d = cnt_q + 15'd1;
          if (cnt_q == 15'd511) begin
            state_d = S_PRG;
            cnt_d   = '0;
          end
        end
      end
      S_PRG: begin
        if (xfer) begin
          prg_wr = 1'b1;
          cnt_d  = cnt_q + 15'd1;
          if (cnt_q == prg_last) begin
            state_d = (hdr5_q == 8'd1) ? S_CHR : S_DONE;
            cnt_d   = '0;
          end
        end
      end
      S_CHR: begin
        if (xfer) begin
          chr_wr = 1'b1;
          cnt_d  = cnt_q + 15'd1;
          if (cnt_q == 15'd8191) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hdr4_q    <= '0;
      hdr5_q    <= '0;
      hdr6_q    <= '0;
      hdr7_q    <= '0;
      hdr8_q    <= '0;
      cfg_q     <= '0;
      cfg_upd_q <= 1'b0;
      prg_we_q  <= 1'b0;
      prg_a_q   <= '0;
      prg_d_q   <= '0;
      chr_we_q  <= 1'b0;
      chr_a_q   <= '0;
      chr_d_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_HDR) && xfer) begin
        case (cnt_q)
          15'd4:   hdr4_q <= data_in;
          15'd5:   hdr5_q <= data_in;
          15'd6:   hdr6_q <= data_in;
          15'd7:   hdr7_q <= data_in;
          15'd8:   hdr8_q <= data_in;
          default: ;
        endcase
      end
      // hdr8 was captured seven bytes earlier, so the full config is stable here.
      cfg_upd_q <= cfg_ld;
      if (cfg_ld) cfg_q <= {hdr4_q, hdr5_q, hdr6_q, hdr7_q, hdr8_q};
      // Address/data only move on a write so they hold between strobes.
      prg_we_q <= prg_wr;
      if (prg_wr) begin
        prg_a_q <= cnt_q;
        prg_d_q <= data_in;
      end
      chr_we_q <= chr_wr;
      if (chr_wr) begin
        chr_a_q <= cnt_q[12:0];
        chr_d_q <= data_in;
      end
    end
  end

  assign cfg_out      = cfg_q;
  assign cfg_upd_out  = cfg_upd_q;
  assign prg_nce_out  = ~prg_we_q;
  assign prg_r_nw_out = ~prg_we_q;
  assign prg_a_out    = prg_a_q;
  assign prg_d_out    = prg_d_q;
  assign chr_r_nw_out = ~chr_we_q;
  assign chr_a_out    = {1'b0, chr_a_q};
  assign chr_d_out    = chr_d_q;

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Ports (name  direction  width  meaning), clock and reset first:
 clk_in  input  1  system clock, all logic on rising edge
 rst_n_in  input  1  reset, asynchronous, active-low
 start_in  input  1  one-cycle pulse: begin loading a new iNES image
 data_in  input  8  image byte stream
 data_valid_in  input  1  data_in holds a valid byte
 data_ready_out  output  1  loader accepts a byte this cycle
 cfg_out  output  40  cartridge config: {hdr[4],hdr[5],hdr[6],hdr[7],hdr[8]}
 cfg_upd_out  output  1  one-cycle pulse when cfg_out is updated
 prg_nce_out  output  1  prog-rom chip enable, active-low
 prg_a_out  output  15  prog-rom address
 prg_r_nw_out  output  1  prog-rom r/w select (0 = write)
 prg_d_out  output  8  prog-rom write data
 chr_a_out  output  14  char-rom address
 chr_r_nw_out  output  1  char-rom r/w select (0 = write)
 chr_d_out  output  8  char-rom write data
 done_out  output  1  image fully loaded
 err_out  output  1  image rejected
REQ-002 Parameters: none.

Function
REQ-003 Byte transfer occurs on a cycle with data_valid_in=1 and data_ready_out=1; exactly one byte per transfer.
REQ-004 States: IDLE, HDR, TRAIN, PRG, CHR, DONE, ERR; data_ready_out=1 only in HDR, TRAIN, PRG, CHR.
REQ-005 start_in in IDLE, DONE or ERR: go to HDR, clear byte counter, done_out and err_out; start_in in HDR/TRAIN/PRG/CHR is ignored.
REQ-006 HDR consumes 16 bytes (index 0-15); bytes 0-3 not equal to 4E,45,53,1A respectively: go to ERR on that transfer.
REQ-007 Header bytes 4-8 captured internally; bytes 9-15 discarded.
REQ-008 On transfer of byte 15: hdr[4] not 1 or 2, or hdr[5] not 0 or 1 -> ERR, cfg_out unchanged, no cfg_upd_out.
REQ-009 Otherwise on byte 15: cfg_out loaded and cfg_upd_out=1 on the following cycle only; next state TRAIN if hdr[6] bit 2 set, else PRG.
REQ-010 TRAIN discards exactly 512 bytes, then PRG.
REQ-011 PRG accepts hdr[4]*16384 bytes; byte n (n from 0) written to prg_a_out=n[14:0], prg_d_out=byte.
REQ-012 After last PRG byte: CHR if hdr[5]=1, else DONE; CHR accepts 8192 bytes, byte n to chr_a_out={1'b0,n[12:0]}.
REQ-013 Write strobe registered: cycle after a PRG transfer, prg_nce_out=0 and prg_r_nw_out=0 for exactly one cycle with matching address/data; otherwise prg_nce_out=1, prg_r_nw_out=1.
REQ-014 Same for CHR: one cycle chr_r_nw_out=0, chr_a_out[13]=0; otherwise chr_r_nw_out=1; prg and chr strobes never coincide.
REQ-015 Back-to-back transfers produce back-to-back single-cycle strobes, no bubbles required; data_valid_in gaps produce no strobe.
REQ-016 Address and data outputs hold their last value between strobes.
REQ-017 Byte counter 15 bits; terminal counts 15, 511, 16383/32767, 8191; counter cleared on each state change.
REQ-018 DONE: done_out=1, data_ready_out=0; ERR: err_out=1, data_ready_out=0; both hold until start_in or reset.
REQ-019 Transfer and start_in in same cycle in IDLE/DONE/ERR: byte not accepted (ready was 0), start honoured.

Reset
REQ-020 rst_n_in=0 forces immediately: state IDLE, counter 0, data_ready_out=0, cfg_out=0, cfg_upd_out=0, prg_nce_out=1, prg_a_out=0, prg_r_nw_out=1, prg_d_out=0, chr_a_out=0, chr_r_nw_out=1, chr_d_out=0, done_out=0, err_out=0.
REQ-021 Reset mid-load aborts without any further strobe; cfg_out cleared.

Verification
REQ-022 Header 4E 45 53 1A 02 01 01 00 00 + 7 zeros, 32768 PRG + 8192 CHR bytes streamed continuously -> cfg_out=40'h0201010000 pulse once, 32768 prg strobes addr 0..7FFF, 8192 chr strobes addr 0000..1FFF, done_out=1.
REQ-023 hdr[4]=01, hdr[5]=00 -> 16384 prg strobes addr 0..3FFF, zero chr strobes, done_out=1.
REQ-024 hdr[6]=04 -> first 512 post-header bytes produce no strobe; byte 528 written to prg addr 0.
REQ-025 Byte 2 = 00 -> err_out=1 on next cycle, no cfg_upd_out, data_ready_out=0; start_in then valid image -> done_out=1.
REQ-026 hdr[4]=03 -> err_out=1 after byte 15, cfg_out stays 0.
REQ-027 Random data_valid_in gaps plus rst_n_in=0 at PRG byte 100 -> all outputs at reset values asynchronously, no strobe after reset.
